fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Second-generation instruction fetch front end. It generates the fetch PC and issues requests to a variable-latency instruction memory over a valid/ready handshake. Returned instructions are buffered in a parametrised in-order fetch queue that decouples fetch from decode. Redirect handling squashes both queued and in-flight fetches, so stale instructions never reach decode. Branch prediction lookup stays outside the block and is supplied combinationally for the PC currently being requested.

Parameters:
WIDTH, 32, instruction/PC width in bits
DEPTH, 4, fetch queue entries (power of two, >=2)
MAX_INFLIGHT, 2, maximum outstanding imem requests (power of two, >=1)
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  input  1  clock, all state updates on posedge
globalReset  input  1  synchronous active-high reset
misdirect  input  1  commit-stage misprediction correction
misdirectTarget  input  WIDTH  corrected PC
isJAL  input  1  decode-stage JAL redirect
jalTarget  input  WIDTH  JAL target PC
predHit  input  1  BTB hit AND PHT taken for imemAddr this cycle
predTarget  input  WIDTH  predicted target for imemAddr
imemReqValid  output  1  request valid
imemAddr  output  WIDTH  request address (current fetch PC)
imemReqReady  input  1  memory accepts request
imemRespValid  input  1  response valid, in request order
imemRespData  input  WIDTH  fetched instruction
decValid  output  1  queue head valid
decInstr  output  WIDTH  head instruction
decPC  output  WIDTH  head PC
decPredPC  output  WIDTH  head predicted next PC
decRedirect  output  1  head fetched under prediction redirect
decReady  input  1  decode consumes head
occupancy  output  $clog2(DEPTH)+1  queued entry count

Behaviour:
- Reset (globalReset high at posedge): PC<=RESET_PC; queue, in-flight FIFO, and drop counter cleared; decValid=0, decInstr/decPC/decPredPC/decRedirect=0, occupancy=0. imemReqValid is 0 in the reset cycle.
- Request issue: imemReqValid=1 when not resetting, no flush this cycle, inflight<MAX_INFLIGHT, and occupancy+inflight<DEPTH (credit rule; the queue can never overflow).
- Request acceptance: imemReqValid&imemReqReady. Pushes {PC, nextPC, predHit} into the in-flight FIFO.
- Next PC, evaluated every cycle, priority highest first:
  - misdirect -> misdirectTarget
  - isJAL -> jalTarget
  - accepted & predHit -> predTarget
  - accepted -> PC+4, mod 2^WIDTH, wraps
  - otherwise PC holds.
- Flush: misdirect or isJAL. Same cycle:
  - queue emptied; the decValid pop is suppressed.
  - dropCount <= inflight minus any response arriving this cycle.
  - in-flight FIFO cleared.
  - no request issued.
- Response: when imemRespValid and dropCount>0, the response is discarded and dropCount decrements. Otherwise it pops the in-flight FIFO and pushes {data, pc, predPC, redirect} to the queue tail.
- A response arriving in the flush cycle is discarded and is not counted in dropCount.
- Decode handshake: decValid=(occupancy>0). Pop on decValid&decReady. Head outputs are registered queue storage, zero-latency from the head pointer.
- Push and pop in the same cycle are both honoured; occupancy unchanged. A push into an empty queue is visible on decValid the next cycle (1-cycle fill latency).
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset takes priority over flush; flush takes priority over push and pop.
- A response with no outstanding request is a protocol error: ignored, no state change.

Test Plan:
- Reset, imemReqReady=1, 1-cycle memory, decReady=1, no predictions -> imemAddr 0,4,8,C...; decPC follows 2 cycles behind; occupancy never exceeds 1.
- decReady=0, DEPTH=4, MAX_INFLIGHT=2 -> exactly 4 entries queued, then imemReqValid=0. Raise decReady -> PCs 0,4,8,C drain in order and fetch resumes at 0x10.
- predHit=1, predTarget=0x100 on request for 0x8 -> next imemAddr=0x100; entry 0x8 has decPredPC=0x100, decRedirect=1.
- 2 requests in flight, misdirect=1, misdirectTarget=0x40 -> queue empty next cycle, both late responses dropped, first decPC=0x40.
- misdirect=1 (0x80) and isJAL=1 (0x200) same cycle -> fetch resumes at 0x80.
- globalReset asserted with a full queue and 2 in flight -> all outputs 0 next cycle, late responses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC generation, imem request issue, and an in-order fetch queue
// to decode. Redirects squash both queued entries and responses still in flight.
module fetch_queue_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     globalReset,
    input  logic                     misdirect,
    input  logic [WIDTH-1:0]         misdirectTarget,
    input  logic                     isJAL,
    input  logic [WIDTH-1:0]         jalTarget,
    input  logic                     predHit,
    input  logic [WIDTH-1:0]         predTarget,
    output logic                     imemReqValid,
    output logic [WIDTH-1:0]         imemAddr,
    input  logic                     imemReqReady,
    input  logic                     imemRespValid,
    input  logic [WIDTH-1:0]         imemRespData,
    output logic                     decValid,
    output logic [WIDTH-1:0]         decInstr,
    output logic [WIDTH-1:0]         decPC,
    output logic [WIDTH-1:0]         decPredPC,
    output logic                     decRedirect,
    input  logic                     decReady,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int QPW = $clog2(DEPTH);
    localparam int OCW = QPW + 1;
    localparam int IPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int ICW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [IPW-1:0] IF_LAST = IPW'(MAX_INFLIGHT - 1);

    logic [WIDTH-1:0] pc, pc_next, seq_target;

    // In-flight FIFO: one entry per accepted request, retired by its response.
    logic [WIDTH-1:0] if_pc    [MAX_INFLIGHT];
    logic [WIDTH-1:0] if_npc   [MAX_INFLIGHT];
    logic             if_redir [MAX_INFLIGHT];
    logic [IPW-1:0]   if_wr, if_rd;
    logic [ICW-1:0]   if_cnt, drop_cnt, outstanding, flush_drop;

    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];
    logic [WIDTH-1:0] q_npc   [DEPTH];
    logic             q_redir [DEPTH];
    logic [QPW-1:0]   q_head, q_tail;

    logic flush, accepted, resp_take, pop;

    function automatic logic [IPW-1:0] if_inc(input logic [IPW-1:0] p);
        return (p == IF_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready. Responses carry no ready and arrive in request order.
    always_comb begin
        flush       = misdirect | isJAL;
        outstanding = if_cnt + drop_cnt;
        flush_drop  = outstanding - ICW'(imemRespValid && (outstanding != '0));
        imemReqValid = !globalReset && !flush
                       && (int'(outstanding) < MAX_INFLIGHT)
                       && ((int'(occupancy) + int'(if_cnt)) < DEPTH);
        accepted   = imemReqValid & imemReqReady;
        seq_target = predHit ? predTarget : pc + WIDTH'(4);
        resp_take  = imemRespValid && !flush && (drop_cnt == '0) && (if_cnt != '0);
        pop        = decValid && decReady && !flush;

        if (misdirect)     pc_next = misdirectTarget;
        else if (isJAL)    pc_next = jalTarget;
        else if (accepted) pc_next = seq_target;
        else               pc_next = pc;
    end

    assign imemAddr    = pc;
    assign decValid    = (occupancy != '0);
    assign decInstr    = q_instr[q_head];
    assign decPC       = q_pc[q_head];
    assign decPredPC   = q_npc[q_head];
    assign decRedirect = q_redir[q_head];

    always_ff @(posedge clk) begin
        if (globalReset) begin
            pc        <= RESET_PC;
            if_wr     <= '0;
            if_rd     <= '0;
            if_cnt    <= '0;
            drop_cnt  <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_npc[i]   <= '0;
                q_redir[i] <= 1'b0;
            end
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if_pc[i]    <= '0;
                if_npc[i]   <= '0;
                if_redir[i] <= 1'b0;
            end
        end else begin
            pc <= pc_next;
            if (flush) begin
                // Everything still outstanding becomes a drop; a response landing now is discarded.
                if_wr     <= '0;
                if_rd     <= '0;
                if_cnt    <= '0;
                drop_cnt  <= flush_drop;
                q_head    <= '0;
                q_tail    <= '0;
                occupancy <= '0;
            end else begin
                if (accepted) begin
                    if_pc[if_wr]    <= pc;
                    if_npc[if_wr]   <= seq_target;
                    if_redir[if_wr] <= predHit;
                    if_wr           <= if_inc(if_wr);
                end
                if (resp_take) begin
                    q_instr[q_tail] <= imemRespData;
                    q_pc[q_tail]    <= if_pc[if_rd];
                    q_npc[q_tail]   <= if_npc[if_rd];
                    q_redir[q_tail] <= if_redir[if_rd];
                    q_tail          <= q_tail + 1'b1;
                    if_rd           <= if_inc(if_rd);
                end
                if (pop) q_head <= q_head + 1'b1;
                if (imemRespValid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                if_cnt    <= if_cnt + ICW'(accepted) - ICW'(resp_take);
                occupancy <= occupancy + OCW'(resp_take) - OCW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: in-order memory model with variable latency, a PC
// model feeding an expected-entry queue, and directed plus random redirect traffic.
module tb_fetch_queue_unit;

    localparam int W = 32;
    localparam int DEPTH = 4;
    localparam int MAXI = 2;
    localparam logic [W-1:0] RPC = '0;

    logic clk = 1'b0;
    logic globalReset, misdirect, isJAL, predHit;
    logic imemReqReady, imemRespValid, decReady;
    logic [W-1:0] misdirectTarget, jalTarget, predTarget, imemRespData;
    logic imemReqValid, decValid, decRedirect;
    logic [W-1:0] imemAddr, decInstr, decPC, decPredPC;
    logic [$clog2(DEPTH):0] occupancy;

    fetch_queue_unit #(.WIDTH(W), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .RESET_PC(RPC)) dut (
        .clk(clk), .globalReset(globalReset),
        .misdirect(misdirect), .misdirectTarget(misdirectTarget),
        .isJAL(isJAL), .jalTarget(jalTarget),
        .predHit(predHit), .predTarget(predTarget),
        .imemReqValid(imemReqValid), .imemAddr(imemAddr), .imemReqReady(imemReqReady),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .decValid(decValid), .decInstr(decInstr), .decPC(decPC), .decPredPC(decPredPC),
        .decRedirect(decRedirect), .decReady(decReady), .occupancy(occupancy)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int max_occ = 0;
    bit pred_en = 1'b0;
    logic [W-1:0] pred_at = '0;
    logic [W-1:0] pred_tgt = '0;
    logic [W-1:0] model_pc = RPC;
    logic [3*W:0] exp_q[$];
    logic [W-1:0] mem_addr_q[$];
    int mem_due_q[$];

    function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
        return a ^ 32'hC0DE_1357;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive memory/prediction at negedge, observe, advance models after posedge.
    task automatic step();
        logic acc, rsp, fl;
        logic [W-1:0] addr, npc;
        logic [3*W:0] e;
        rsp = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        imemRespValid = rsp;
        imemRespData = rsp ? data_of(mem_addr_q[0]) : '0;
        predHit = pred_en && (model_pc == pred_at);
        predTarget = pred_tgt;
        #1;
        fl = misdirect | isJAL;
        acc = imemReqValid & imemReqReady;
        addr = imemAddr;
        if (!$isunknown(occupancy) && int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (globalReset) begin
            check("req_in_reset", 32'(imemReqValid), 0);
            exp_q.delete();
            model_pc = RPC;
        end else if (fl) begin
            check("req_in_flush", 32'(imemReqValid), 0);
            exp_q.delete();
            model_pc = misdirect ? misdirectTarget : jalTarget;
        end else begin
            if (decValid && decReady) begin
                if (exp_q.size() == 0) begin
                    check("dec_spurious", 32'(decValid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_instr", decInstr, e[3*W:2*W+1]);
                    check("dec_pc", decPC, e[2*W:W+1]);
                    check("dec_pred_pc", decPredPC, e[W:1]);
                    check("dec_redirect", 32'(decRedirect), 32'(e[0]));
                end
            end
            if (acc) begin
                check("imem_addr", addr, model_pc);
                npc = predHit ? pred_tgt : model_pc + 32'd4;
                exp_q.push_back({data_of(model_pc), model_pc, npc, predHit});
                model_pc = npc;
            end
        end
        @(posedge clk);
        cyc++;
        if (rsp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (acc) begin
            mem_addr_q.push_back(addr);
            mem_due_q.push_back(cyc + lat - 1);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        imemReqReady = 1'b0;
        for (int i = 0; i < 20 && mem_addr_q.size() > 0; i++) step();
        globalReset = 1'b1;
        step();
        globalReset = 1'b0;
        imemReqReady = 1'b1;
    endtask

    task automatic wait_dec(input string tag);
        int n;
        n = 0;
        while (!decValid && n < 30) begin
            step();
            n++;
        end
        check(tag, 32'(decValid), 1);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_dec_valid"}, 32'(decValid), 0);
        check({pfx, "_dec_instr"}, decInstr, 0);
        check({pfx, "_dec_pc"}, decPC, 0);
        check({pfx, "_dec_pred_pc"}, decPredPC, 0);
        check({pfx, "_dec_redirect"}, 32'(decRedirect), 0);
        check({pfx, "_occupancy"}, 32'(occupancy), 0);
        check({pfx, "_imem_addr"}, imemAddr, RPC);
    endtask

    initial begin
        // Reset
        globalReset = 1'b1;
        misdirect = 1'b0; isJAL = 1'b0; predHit = 1'b0;
        misdirectTarget = '0; jalTarget = '0; predTarget = '0;
        imemReqReady = 1'b1; imemRespValid = 1'b0; imemRespData = '0; decReady = 1'b1;
        @(negedge clk);
        step();
        step();
        globalReset = 1'b0;
        check_zero_outputs("rst");

        // Streaming with a 1-cycle memory: decode sees each PC two cycles after request
        max_occ = 0;
        step();
        check("p1_fill_c1", 32'(decValid), 0);
        step();
        check("p1_fill_c2", 32'(decValid), 1);
        check("p1_first_pc", decPC, 32'h0);
        repeat (20) step();
        check("p1_max_occ", 32'(max_occ), 1);

        // Decode stalled: credit rule stops fetch at a full queue
        do_reset();
        decReady = 1'b0;
        repeat (10) step();
        check("p2_occ_full", 32'(occupancy), 32'(DEPTH));
        check("p2_req_stalled", 32'(imemReqValid), 0);
        check("p2_head_pc", decPC, 32'h0);
        decReady = 1'b1;
        repeat (12) step();

        // Predicted-taken fetch at 0x8
        do_reset();
        pred_en = 1'b1; pred_at = 32'h8; pred_tgt = 32'h100;
        decReady = 1'b0;
        repeat (10) step();
        decReady = 1'b1;
        step();
        step();
        decReady = 1'b0;
        check("p3_head_pc", decPC, 32'h8);
        check("p3_head_pred_pc", decPredPC, 32'h100);
        check("p3_head_redirect", 32'(decRedirect), 1);
        decReady = 1'b1;
        step();
        check("p3_target_pc", decPC, 32'h100);
        pred_en = 1'b0;
        repeat (4) step();

        // Misdirect with two requests outstanding
        lat = 2;
        for (int i = 0; i < 10 && mem_addr_q.size() != 2; i++) step();
        misdirect = 1'b1; misdirectTarget = 32'h40;
        step();
        misdirect = 1'b0;
        check("p4_queue_empty", 32'(decValid), 0);
        check("p4_occ_zero", 32'(occupancy), 0);
        decReady = 1'b0;
        wait_dec("p4_refill");
        check("p4_first_pc", decPC, 32'h40);
        decReady = 1'b1;
        repeat (6) step();

        // Misdirect outranks JAL
        misdirect = 1'b1; misdirectTarget = 32'h80;
        isJAL = 1'b1; jalTarget = 32'h200;
        step();
        misdirect = 1'b0; isJAL = 1'b0;
        decReady = 1'b0;
        wait_dec("p5_refill");
        check("p5_first_pc", decPC, 32'h80);
        decReady = 1'b1;
        repeat (4) step();

        // Reset with queued entries and two requests in flight
        do_reset();
        lat = 2;
        decReady = 1'b0;
        for (int i = 0; i < 12 && !(mem_addr_q.size() == 2 && occupancy >= 2); i++) step();
        check("p6_setup_occ", 32'(occupancy >= 2), 1);
        globalReset = 1'b1;
        step();
        globalReset = 1'b0;
        check_zero_outputs("p6");
        decReady = 1'b1;
        repeat (10) step();

        // Random traffic
        pred_at = 32'h20; pred_tgt = 32'h4;
        for (int i = 0; i < 400; i++) begin
            imemReqReady = ($urandom_range(0, 3) != 0);
            decReady = ($urandom_range(0, 2) != 0);
            lat = $urandom_range(1, 3);
            pred_en = ($urandom_range(0, 1) != 0);
            misdirect = ($urandom_range(0, 39) == 0);
            misdirectTarget = W'($urandom_range(0, 255)) << 2;
            isJAL = ($urandom_range(0, 39) == 0);
            jalTarget = W'($urandom_range(0, 255)) << 2;
            step();
        end
        misdirect = 1'b0; isJAL = 1'b0; pred_en = 1'b0;
        imemReqReady = 1'b0; decReady = 1'b1;
        repeat (10) step();
        check("final_drained", 32'(decValid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
